// File: rtl/arf_responder_pkg.sv
// arf_pkg: shared defaults and the level-width helper for the arf_responder slice.
package arf_pkg;

  localparam int ARF_DATA_W = 32;
  localparam int ARF_DEPTH  = 4;

  // level must represent 0..depth inclusive, hence one bit above the pointer width
  function automatic int lvl_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/arf_responder_if.sv
// arf_responder_if: push side, per-consumer request/ack and broadcast data.
// Optional ARF_RESPONDER_STATS_EN adds the per-consumer delivered-word counters.
interface arf_responder_if
  import arf_pkg::*;
#(
  parameter int data_width  = ARF_DATA_W,
  parameter int depth       = ARF_DEPTH,
  parameter int output_size = 2
);

  logic                         wr_en;
  logic [data_width-1:0]        wr_data;
  logic                         full;
  logic [lvl_w(depth)-1:0]      level;
  logic [output_size-1:0]       req;
  logic [output_size-1:0]       ack;
  logic [data_width-1:0]        dout;
`ifdef ARF_RESPONDER_STATS_EN
  logic [output_size*32-1:0]    count;

  modport master (output wr_en, wr_data, req, input full, level, ack, dout, count);
  modport slave  (input wr_en, wr_data, req, output full, level, ack, dout, count);
`else
  modport master (output wr_en, wr_data, req, input full, level, ack, dout);
  modport slave  (input wr_en, wr_data, req, output full, level, ack, dout);
`endif

endinterface

// File: rtl/arf_responder_fifo.sv
// arf_resp_fifo: storage for arf_responder -- memory, wrapping pointers, level, full/empty.
// The caller guarantees push only when !full and pop only when !empty.
module arf_resp_fifo
  import arf_pkg::*;
#(
  parameter int data_width = ARF_DATA_W,
  parameter int depth      = ARF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [data_width-1:0]   wr_data,
  input  logic                    pop,
  output logic [data_width-1:0]   head,
  output logic [lvl_w(depth)-1:0] level,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(depth);
  localparam int LW = lvl_w(depth);

  logic [data_width-1:0] mem [depth];
  logic [PW-1:0]         wr_ptr, rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(depth));
  assign empty = (level == '0);

  // storage array; contents are don't-care until level says otherwise, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // pointers wrap naturally (depth is a power of two); level tracks push minus pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/arf_responder.sv
// arf_responder: broadcast FIFO -- every pushed word is handed once to each consumer,
// in push order, via a registered one-cycle ack and a registered dout.
// Optional ARF_RESPONDER_STATS_EN adds bus.count (32-bit delivered-word counter per consumer).
module arf_responder
  import arf_pkg::*;
#(
  parameter int data_width  = ARF_DATA_W,
  parameter int depth       = ARF_DEPTH,
  parameter int output_size = 2
) (
  input  logic            clk,
  input  logic            rst,
  arf_responder_if.slave  bus
);

  logic [output_size-1:0] grant, taken, taken_nxt, ack_q;
  logic [data_width-1:0]  head, dout_q;
  logic                   push, pop, full, empty;
  logic [lvl_w(depth)-1:0] level;

  // writes while full are dropped even if the head pops this same edge
  assign push = bus.wr_en & ~full;

  // a consumer is served once per head word, and never on back-to-back cycles
  for (genvar i = 0; i < output_size; i++) begin : g_lane
    assign grant[i] = bus.req[i] & ~ack_q[i] & ~taken[i] & ~empty;
  end

  assign taken_nxt = taken | grant;
  assign pop       = ~empty & (&taken_nxt);

  arf_resp_fifo #(.data_width(data_width), .depth(depth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (bus.wr_data),
    .pop     (pop),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // ack/taken bookkeeping; dout captures the head only when someone is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q  <= '0;
      taken  <= '0;
      dout_q <= '0;
    end else begin
      ack_q <= grant;
      taken <= pop ? '0 : taken_nxt;
      if (|grant) dout_q <= head;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.dout  = dout_q;
  assign bus.full  = full;
  assign bus.level = level;

`ifdef ARF_RESPONDER_STATS_EN
  for (genvar i = 0; i < output_size; i++) begin : g_cnt
    logic [31:0] cnt;
    // counts delivered words; bumps on the edge that raises ack[i], wraps at 2^32
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          cnt <= '0;
      else if (grant[i]) cnt <= cnt + 32'd1;
    end
    assign bus.count[i*32 +: 32] = cnt;
  end
`endif

endmodule

// File: doc/arf_responder.md
ARF_RESPONDER -- requirements
Module: arf_responder

Interface
REQ-001 SHALL have parameter data_width, default 32, width of every data word.
REQ-002 SHALL have parameter depth, default 4, FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter output_size, default 2, number of independent requesting consumers.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  push strobe.
REQ-007 SHALL have port wr_data  input  data_width  word to push.
REQ-008 SHALL have port full  output  1  FIFO holds depth words.
REQ-009 SHALL have port level  output  clog2(depth)+1  words currently held.
REQ-010 SHALL have port req  input  output_size  per-consumer request, level-held by consumer.
REQ-011 SHALL have port ack  output  output_size  per-consumer one-cycle acknowledge.
REQ-012 SHALL have port dout  output  data_width  registered head word, valid from the edge raising any ack bit.

Function
REQ-013 Broadcast: every pushed word SHALL be delivered exactly once to each of the output_size consumers, in push order.
REQ-014 Push: wr_en=1 and full=0 SHALL store wr_data at the write pointer; wr_en while full SHALL be dropped, even if a pop occurs the same cycle.
REQ-015 Per consumer i, per cycle: ack[i] SHALL be registered 1 iff req[i]=1, ack[i]=0, FIFO not empty, taken[i]=0; otherwise ack[i] registers 0.
REQ-016 On any ack grant, dout SHALL load the head word; taken[i] SHALL set for every granted i.
REQ-017 Pop: when all taken bits (including grants this cycle) are set, read pointer SHALL advance modulo depth and all taken bits SHALL clear on the same edge.
REQ-018 Pointers SHALL wrap modulo depth; full and empty SHALL derive from level (level==depth, level==0).
REQ-019 Simultaneous push and pop SHALL leave level unchanged.
REQ-020 Latency: word pushed at edge t SHALL be grantable at edge t+1 earliest; each consumer sustains at most one ack per two cycles.
REQ-021 dout SHALL hold its value between grants; consumers granted the same head word SHALL observe identical dout.

Reset
REQ-022 rst=0 SHALL asynchronously clear pointers, level, taken bits, ack, dout to 0; full=0.
REQ-023 Reset mid-transfer SHALL discard all stored words and partial deliveries; no ack SHALL issue during reset or on the first edge after release.

Configuration
REQ-024 With ARF_RESPONDER_STATS_EN defined, SHALL add output count  output_size*32, per-consumer delivered-word counters incremented on each ack, cleared by reset, wrapping at 2^32.
REQ-025 Without ARF_RESPONDER_STATS_EN, port count and its counters SHALL be absent; all other behaviour identical.

Structure
REQ-026 Shared package arf_pkg SHALL hold default data_width, default depth and the level-width helper function.
REQ-027 Storage SHALL be one sub-module arf_resp_fifo (memory, pointers, level, full/empty); grant/taken logic in the top.

Verification
REQ-028 Push 0x11,0x22,0x33; req=2'b11 held -> each consumer gets three acks, dout 0x11,0x22,0x33 in order; level ends 0.
REQ-029 Push 0xA5; req=2'b01 for 10 cycles, then req=2'b11 -> consumer0 one ack only, no pop until consumer1 acks; level 1 then 0.
REQ-030 Push 5 words with depth=4, no req -> full=1 after 4th, 5th (0x55) dropped, level=4.
REQ-031 At level=4 with pending final ack, assert wr_en -> write dropped, level becomes 3; at level=2 push+pop same edge -> level stays 2.
REQ-032 Push 8 words, drain, repeat twice -> pointers wrap, order preserved, no duplicate or missing acks.
REQ-033 Assert rst=0 between edges with level=3 and taken=2'b01 -> outputs clear immediately; after release no ack until a new push; with ARF_RESPONDER_STATS_EN counts read 0.
